// File: rtl/fft_peak_finder.sv
// -----------------------------------------------------------------------------
// fft_peak_finder
//
// Watches the FFT output stream (one complex bin per bin_valid strobe, frames
// started by a rising edge on sync_o). For each bin it forms an
// alpha-max-beta-min magnitude estimate, max(|re|,|im|) + min(|re|,|im|)/2.
// It keeps the largest bin seen in the frame and reports it once the frame
// has drained through the magnitude pipeline.
//
// Ports
//   global_clk   system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   sync_o       frame marker from the FFT; a rising edge starts a frame
//   bin_valid    one-cycle strobe qualifying fft_re / fft_im
//   fft_re       signed real part of the current bin
//   fft_im       signed imaginary part of the current bin
//   peak_bin     index of the largest bin of the last completed frame
//   peak_mag     magnitude of that bin
//   peak_found   peak_mag >= THRESH
//   peak_valid   one-cycle pulse: peak_bin/peak_mag/peak_found were updated
//   frame_abort  one-cycle pulse: a frame was cut short by a new sync edge
//   busy         high while a frame is being accumulated or drained
//
// Timing: peak_valid rises 4 clocks after the edge that samples the final
// beat. That is 3 clocks for the magnitude pipeline plus one for REPORT.
// -----------------------------------------------------------------------------
module fft_peak_finder #(
   parameter int N_BINS  = 128,
   parameter int DATA_W  = 8,
   parameter int SKIP_DC = 1,
   parameter int THRESH  = 16,
   localparam int IDX_W  = $clog2(N_BINS)
) (
   input  logic                     global_clk,
   input  logic                     rst,
   input  logic                     sync_o,
   input  logic                     bin_valid,
   input  logic signed [DATA_W-1:0] fft_re,
   input  logic signed [DATA_W-1:0] fft_im,
   output logic [IDX_W-1:0]         peak_bin,
   output logic [DATA_W-1:0]        peak_mag,
   output logic                     peak_found,
   output logic                     peak_valid,
   output logic                     frame_abort,
   output logic                     busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);
   // With DC skipped, an empty frame reports bin 1 rather than the DC bin.
   localparam logic [IDX_W-1:0] INIT_IDX = (SKIP_DC != 0) ? IDX_W'(1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

   state_t             state_reg;
   logic [IDX_W-1:0]   bin_cnt_reg;
   logic               sync_prev_reg;

   logic               sync_edge;
   logic               start_frame;
   logic               beat_in;

   // Stage 1: absolute values
   logic               s1_valid_reg;
   logic               s1_last_reg;
   logic [IDX_W-1:0]   s1_idx_reg;
   logic [DATA_W-1:0]  s1_a_reg;
   logic [DATA_W-1:0]  s1_b_reg;

   // Stage 2: magnitude estimate
   logic               s2_valid_reg;
   logic               s2_last_reg;
   logic [IDX_W-1:0]   s2_idx_reg;
   logic [DATA_W-1:0]  s2_mag_reg;
   logic [DATA_W-1:0]  s2_big;
   logic [DATA_W-1:0]  s2_small;
   logic [DATA_W-1:0]  s2_mag_next;

   // Stage 3: running maximum
   logic [DATA_W-1:0]  max_mag_reg;
   logic [IDX_W-1:0]   max_idx_reg;
   logic               s3_last_reg;
   logic               dc_blocked;
   logic               s3_update;

   // Per-lane inputs and absolute values (0 = real, 1 = imaginary)
   logic [DATA_W-1:0]  lane_in  [2];
   logic [DATA_W-1:0]  lane_abs [2];

   // -------------------------------------------------------------------------
   // Frame control decode
   // -------------------------------------------------------------------------
   // sync_o is produced on-chip in this clock domain, so one register is
   // enough to find its rising edge.
   assign sync_edge   = sync_o && !sync_prev_reg;

   // A new frame starts from IDLE or restarts (abort) from ACCUM. Edges in
   // DRAIN/REPORT are dropped on purpose: that frame is lost.
   assign start_frame = sync_edge && ((state_reg == ST_IDLE) || (state_reg == ST_ACCUM));

   // A beat that coincides with a sync edge belongs to no frame.
   assign beat_in     = (state_reg == ST_ACCUM) && bin_valid && !sync_edge;

   // -------------------------------------------------------------------------
   // Stage 1 combinational: absolute value per lane. Two's-complement negate
   // in DATA_W bits, read as unsigned, so the most negative code maps to
   // 2^(DATA_W-1) without needing an extra bit.
   // -------------------------------------------------------------------------
   assign lane_in[0] = fft_re;
   assign lane_in[1] = fft_im;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_lane_abs
         assign lane_abs[gi] = lane_in[gi][DATA_W-1]
                             ? ((~lane_in[gi]) + DATA_W'(1))
                             : lane_in[gi];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Stage 2 combinational: alpha-max-beta-min with alpha = 1, beta = 1/2.
   // The largest result is 2^(DATA_W-1) + 2^(DATA_W-2), so DATA_W bits hold it.
   // -------------------------------------------------------------------------
   assign s2_big      = (s1_a_reg >= s1_b_reg) ? s1_a_reg : s1_b_reg;
   assign s2_small    = (s1_a_reg >= s1_b_reg) ? s1_b_reg : s1_a_reg;
   assign s2_mag_next = s2_big + (s2_small >> 1);

   // -------------------------------------------------------------------------
   // Stage 3 combinational: strict greater-than, so on ties the earliest
   // (lowest index) bin is kept.
   // -------------------------------------------------------------------------
   assign dc_blocked = (SKIP_DC != 0) && (s2_idx_reg == '0);
   assign s3_update  = s2_valid_reg && !dc_blocked && (s2_mag_reg > max_mag_reg);

   // -------------------------------------------------------------------------
   // Pipeline control: valid/last flags and the running max. These are
   // flushed by reset and whenever a frame (re)starts, so an aborted frame
   // can never leak beats into the next one.
   // -------------------------------------------------------------------------
   always_ff @(posedge global_clk) begin
      if (rst || start_frame) begin
         s1_valid_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s2_valid_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         s3_last_reg  <= 1'b0;
         max_mag_reg  <= '0;
         max_idx_reg  <= INIT_IDX;
      end else begin
         s1_valid_reg <= beat_in;
         s1_last_reg  <= beat_in && (bin_cnt_reg == LAST_IDX);
         s2_valid_reg <= s1_valid_reg;
         s2_last_reg  <= s1_valid_reg && s1_last_reg;
         // s3_last_reg marks the cycle after the last beat updated the max.
         s3_last_reg  <= s2_valid_reg && s2_last_reg;
         if (s3_update) begin
            max_mag_reg <= s2_mag_reg;
            max_idx_reg <= s2_idx_reg;
         end
      end
   end

   // Pipeline data registers: qualified by the valid flags above, so they
   // carry no reset.
   always_ff @(posedge global_clk) begin
      s1_idx_reg <= bin_cnt_reg;
      s1_a_reg   <= lane_abs[0];
      s1_b_reg   <= lane_abs[1];
      s2_idx_reg <= s1_idx_reg;
      s2_mag_reg <= s2_mag_next;
   end

   // -------------------------------------------------------------------------
   // Frame FSM with registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge global_clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         bin_cnt_reg   <= '0;
         sync_prev_reg <= 1'b0;
         peak_bin      <= '0;
         peak_mag      <= '0;
         peak_found    <= 1'b0;
         peak_valid    <= 1'b0;
         frame_abort   <= 1'b0;
         busy          <= 1'b0;
      end else begin
         sync_prev_reg <= sync_o;
         peak_valid    <= 1'b0;
         frame_abort   <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               busy <= 1'b0;
               if (sync_edge) begin
                  bin_cnt_reg <= '0;
                  state_reg   <= ST_ACCUM;
                  busy        <= 1'b1;
               end
            end

            ST_ACCUM: begin
               if (sync_edge) begin
                  // Restart; only a frame that actually received beats
                  // counts as aborted.
                  frame_abort <= (bin_cnt_reg != '0);
                  bin_cnt_reg <= '0;
               end else if (bin_valid) begin
                  bin_cnt_reg <= bin_cnt_reg + IDX_W'(1);
                  if (bin_cnt_reg == LAST_IDX) begin
                     state_reg <= ST_DRAIN;
                  end
               end
            end

            ST_DRAIN: begin
               if (s3_last_reg) begin
                  state_reg <= ST_REPORT;
               end
            end

            ST_REPORT: begin
               peak_bin   <= max_idx_reg;
               peak_mag   <= max_mag_reg;
               peak_found <= (int'(max_mag_reg) >= THRESH);
               peak_valid <= 1'b1;
               busy       <= 1'b0;
               state_reg  <= ST_IDLE;
            end

            default: begin
               state_reg <= ST_IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_fft_peak_finder
//
// Self-checking bench for fft_peak_finder. Frames are built in arrays; the
// expected peak is computed from them by a plain arithmetic reference model.
// Each scenario task drives its frames and checks the DUT inline.
// -----------------------------------------------------------------------------
module tb_fft_peak_finder;

   localparam int N_BINS  = 128;
   localparam int DATA_W  = 8;
   localparam int SKIP_DC = 1;
   localparam int THRESH  = 16;
   localparam int IDX_W   = $clog2(N_BINS);

   logic                     global_clk;
   logic                     rst;
   logic                     sync_o;
   logic                     bin_valid;
   logic signed [DATA_W-1:0] fft_re;
   logic signed [DATA_W-1:0] fft_im;
   logic [IDX_W-1:0]         peak_bin;
   logic [DATA_W-1:0]        peak_mag;
   logic                     peak_found;
   logic                     peak_valid;
   logic                     frame_abort;
   logic                     busy;

   int re_arr [N_BINS];
   int im_arr [N_BINS];

   int vectors;
   int miscompares;

   // Most recent expected report, used to check that outputs hold.
   int last_bin;
   int last_mag;
   int last_found;

   fft_peak_finder #(
      .N_BINS  (N_BINS),
      .DATA_W  (DATA_W),
      .SKIP_DC (SKIP_DC),
      .THRESH  (THRESH)
   ) dut (
      .global_clk  (global_clk),
      .rst         (rst),
      .sync_o      (sync_o),
      .bin_valid   (bin_valid),
      .fft_re      (fft_re),
      .fft_im      (fft_im),
      .peak_bin    (peak_bin),
      .peak_mag    (peak_mag),
      .peak_found  (peak_found),
      .peak_valid  (peak_valid),
      .frame_abort (frame_abort),
      .busy        (busy)
   );

   initial global_clk = 1'b0;
   always #5 global_clk = ~global_clk;

   // ---------------------------------------------------------------- model
   function automatic int mag_of(input int re, input int im);
      int a;
      int b;
      a = (re < 0) ? -re : re;
      b = (im < 0) ? -im : im;
      return (a > b) ? (a + b / 2) : (b + a / 2);
   endfunction

   function automatic void model_peak(output int bin, output int mag, output int found);
      int m;
      bin = (SKIP_DC != 0) ? 1 : 0;
      mag = 0;
      for (int i = 0; i < N_BINS; i++) begin
         if (SKIP_DC != 0 && i == 0) continue;
         m = mag_of(re_arr[i], im_arr[i]);
         if (m > mag) begin
            mag = m;
            bin = i;
         end
      end
      found = (mag >= THRESH) ? 1 : 0;
   endfunction

   // ---------------------------------------------------------------- stimulus
   task automatic clear_frame();
      for (int i = 0; i < N_BINS; i++) begin
         re_arr[i] = 0;
         im_arr[i] = 0;
      end
   endtask

   task automatic random_frame(input int lim);
      for (int i = 0; i < N_BINS; i++) begin
         re_arr[i] = int'($urandom_range(0, 2 * lim)) - lim;
         im_arr[i] = int'($urandom_range(0, 2 * lim)) - lim;
      end
   endtask

   // Rising edge on sync_o; returns frame_abort as seen right after the edge.
   task automatic pulse_sync(output int abort_obs);
      @(negedge global_clk);
      sync_o    = 1'b1;
      bin_valid = 1'b0;
      @(negedge global_clk);
      abort_obs = int'(frame_abort);
      sync_o    = 1'b0;
   endtask

   // Drives beats first..first+count-1 with one beat every 'pace' cycles.
   // No idle padding after the frame's final bin, so latency is measured
   // from its sampling edge.
   task automatic send_beats(input int first, input int count, input int pace,
                             output int busy_mid);
      busy_mid = 0;
      for (int i = first; i < first + count; i++) begin
         if (i == first + count / 2) busy_mid = int'(busy);
         bin_valid = 1'b1;
         fft_re    = 8'(re_arr[i]);
         fft_im    = 8'(im_arr[i]);
         @(negedge global_clk);
         bin_valid = 1'b0;
         if (i != N_BINS - 1) begin
            for (int k = 1; k < pace; k++) @(negedge global_clk);
         end
      end
      bin_valid = 1'b0;
   endtask

   // Counts clocks after the final beat until peak_valid; -1 on timeout.
   task automatic wait_report(output int lat, output int pb, output int pm, output int pf,
                              output int pv_after, output int busy_after);
      lat = -1; pb = -1; pm = -1; pf = -1;
      for (int k = 1; k <= 16; k++) begin
         @(negedge global_clk);
         if (peak_valid) begin
            lat = k;
            pb  = int'(peak_bin);
            pm  = int'(peak_mag);
            pf  = int'(peak_found);
            break;
         end
      end
      @(negedge global_clk);
      pv_after   = int'(peak_valid);
      busy_after = int'(busy);
      $display("frame report: bin=%0d mag=%0d found=%0d latency=%0d", pb, pm, pf, lat);
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      rst = 1'b1; sync_o = 1'b0; bin_valid = 1'b0; fft_re = '0; fft_im = '0;
      repeat (3) @(negedge global_clk);
      rst = 1'b0;
      @(negedge global_clk);
      vectors++;
      if ({peak_bin, peak_mag, peak_found, peak_valid, frame_abort, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset.outputs got bin=%0d mag=%0d found=%b valid=%b abort=%b busy=%b want all 0",
                  peak_bin, peak_mag, peak_found, peak_valid, frame_abort, busy);
      end
   endtask

   task automatic test_single_frame();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      clear_frame();
      re_arr[37] = -100;
      im_arr[37] = 40;
      model_peak(eb, em, ef);
      pulse_sync(ab);
      send_beats(0, N_BINS, 1, bm);
      wait_report(lat, pb, pm, pf, pva, ba);
      vectors++;
      if (ab !== 0) begin miscompares++; $display("FAIL single.abort got %0d want 0", ab); end
      vectors++;
      if (bm !== 1) begin miscompares++; $display("FAIL single.busy_mid got %0d want 1", bm); end
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL single.latency got %0d want 4", lat); end
      vectors++;
      if (pb !== eb) begin miscompares++; $display("FAIL single.peak_bin got %0d want %0d", pb, eb); end
      vectors++;
      if (pm !== em) begin miscompares++; $display("FAIL single.peak_mag got %0d want %0d", pm, em); end
      vectors++;
      if (pf !== ef) begin miscompares++; $display("FAIL single.peak_found got %0d want %0d", pf, ef); end
      vectors++;
      if (pva !== 0) begin miscompares++; $display("FAIL single.valid_pulse got %0d want 0", pva); end
      vectors++;
      if (ba !== 0) begin miscompares++; $display("FAIL single.busy_after got %0d want 0", ba); end
      last_bin = eb; last_mag = em; last_found = ef;
   endtask

   task automatic test_tie_dc();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      clear_frame();
      re_arr[0] = 127; im_arr[0] = 127;
      re_arr[5] = 50;
      re_arr[9] = 50;
      model_peak(eb, em, ef);
      pulse_sync(ab);
      send_beats(0, N_BINS, 1, bm);
      wait_report(lat, pb, pm, pf, pva, ba);
      vectors++;
      if (pb !== eb) begin miscompares++; $display("FAIL tie_dc.peak_bin got %0d want %0d", pb, eb); end
      vectors++;
      if (pm !== em) begin miscompares++; $display("FAIL tie_dc.peak_mag got %0d want %0d", pm, em); end
      last_bin = eb; last_mag = em; last_found = ef;
   endtask

   task automatic test_extremes();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      for (int sc = 0; sc < 3; sc++) begin
         clear_frame();
         if (sc == 0) begin
            re_arr[64] = -128; im_arr[64] = -128;
         end else if (sc == 2) begin
            random_frame(5);
            re_arr[20] = 10; im_arr[20] = -10;
         end
         model_peak(eb, em, ef);
         pulse_sync(ab);
         send_beats(0, N_BINS, 1, bm);
         wait_report(lat, pb, pm, pf, pva, ba);
         vectors++;
         if (lat !== 4) begin miscompares++; $display("FAIL extremes%0d.latency got %0d want 4", sc, lat); end
         vectors++;
         if (pb !== eb) begin miscompares++; $display("FAIL extremes%0d.peak_bin got %0d want %0d", sc, pb, eb); end
         vectors++;
         if (pm !== em) begin miscompares++; $display("FAIL extremes%0d.peak_mag got %0d want %0d", sc, pm, em); end
         vectors++;
         if (pf !== ef) begin miscompares++; $display("FAIL extremes%0d.peak_found got %0d want %0d", sc, pf, ef); end
         last_bin = eb; last_mag = em; last_found = ef;
      end
   endtask

   task automatic test_pacing();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      int pb_slow, pm_slow;
      random_frame(127);
      model_peak(eb, em, ef);
      pb_slow = -1; pm_slow = -1;
      for (int pace = 2; pace >= 1; pace--) begin
         pulse_sync(ab);
         send_beats(0, N_BINS, pace, bm);
         wait_report(lat, pb, pm, pf, pva, ba);
         vectors++;
         if (lat !== 4) begin miscompares++; $display("FAIL pacing%0d.latency got %0d want 4", pace, lat); end
         vectors++;
         if (pb !== eb) begin miscompares++; $display("FAIL pacing%0d.peak_bin got %0d want %0d", pace, pb, eb); end
         vectors++;
         if (pm !== em) begin miscompares++; $display("FAIL pacing%0d.peak_mag got %0d want %0d", pace, pm, em); end
         if (pace == 2) begin
            pb_slow = pb; pm_slow = pm;
         end
      end
      vectors++;
      if (pb !== pb_slow || pm !== pm_slow) begin
         miscompares++;
         $display("FAIL pacing.same_result got bin=%0d mag=%0d want bin=%0d mag=%0d", pb, pm, pb_slow, pm_slow);
      end
      last_bin = eb; last_mag = em; last_found = ef;
   endtask

   task automatic test_abort();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      random_frame(20);
      re_arr[100] = 90; im_arr[100] = -60;
      model_peak(eb, em, ef);
      pulse_sync(ab);
      send_beats(0, 60, 1, bm);
      pulse_sync(ab);
      vectors++;
      if (ab !== 1) begin miscompares++; $display("FAIL abort.pulse got %0d want 1", ab); end
      @(negedge global_clk);
      vectors++;
      if (frame_abort !== 1'b0) begin miscompares++; $display("FAIL abort.single_pulse got %b want 0", frame_abort); end
      vectors++;
      if (int'(peak_bin) !== last_bin || int'(peak_mag) !== last_mag || int'(peak_found) !== last_found) begin
         miscompares++;
         $display("FAIL abort.hold got bin=%0d mag=%0d found=%b want bin=%0d mag=%0d found=%0d",
                  peak_bin, peak_mag, peak_found, last_bin, last_mag, last_found);
      end
      send_beats(0, N_BINS, 1, bm);
      wait_report(lat, pb, pm, pf, pva, ba);
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL abort.latency got %0d want 4", lat); end
      vectors++;
      if (pb !== eb) begin miscompares++; $display("FAIL abort.peak_bin got %0d want %0d", pb, eb); end
      vectors++;
      if (pm !== em) begin miscompares++; $display("FAIL abort.peak_mag got %0d want %0d", pm, em); end
      last_bin = eb; last_mag = em; last_found = ef;
   endtask

   task automatic test_reset_mid();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      int seen;
      random_frame(127);
      pulse_sync(ab);
      send_beats(0, 70, 1, bm);
      rst = 1'b1;
      @(negedge global_clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge global_clk);
         if (peak_valid || frame_abort) seen++;
      end
      vectors++;
      if (seen !== 0) begin miscompares++; $display("FAIL reset_mid.no_pulse got %0d pulses want 0", seen); end
      vectors++;
      if ({peak_bin, peak_mag, peak_found, busy} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid.cleared got bin=%0d mag=%0d found=%b busy=%b want all 0",
                  peak_bin, peak_mag, peak_found, busy);
      end
      random_frame(127);
      model_peak(eb, em, ef);
      pulse_sync(ab);
      send_beats(0, N_BINS, 1, bm);
      wait_report(lat, pb, pm, pf, pva, ba);
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL reset_mid.latency got %0d want 4", lat); end
      vectors++;
      if (pb !== eb || pm !== em || pf !== ef) begin
         miscompares++;
         $display("FAIL reset_mid.report got bin=%0d mag=%0d found=%0d want bin=%0d mag=%0d found=%0d",
                  pb, pm, pf, eb, em, ef);
      end
      last_bin = eb; last_mag = em; last_found = ef;
   endtask

   task automatic test_random();
      int eb, em, ef, ab, bm, lat, pb, pm, pf, pva, ba;
      int pace, lim;
      for (int f = 0; f < 5; f++) begin
         pace = int'($urandom_range(1, 3));
         lim  = (f == 0) ? 12 : 127;
         random_frame(lim);
         model_peak(eb, em, ef);
         pulse_sync(ab);
         send_beats(0, N_BINS, pace, bm);
         wait_report(lat, pb, pm, pf, pva, ba);
         vectors++;
         if (lat !== 4) begin miscompares++; $display("FAIL random%0d.latency got %0d want 4", f, lat); end
         vectors++;
         if (pb !== eb || pm !== em || pf !== ef) begin
            miscompares++;
            $display("FAIL random%0d.report got bin=%0d mag=%0d found=%0d want bin=%0d mag=%0d found=%0d",
                     f, pb, pm, pf, eb, em, ef);
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      last_bin    = 0;
      last_mag    = 0;
      last_found  = 0;
      test_reset();
      test_single_frame();
      test_tie_dc();
      test_extremes();
      test_pacing();
      test_abort();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fft_peak_finder.md
Name: fft_peak_finder

Overview:
- Consumes the FFT output stream downstream of fft_controller: signed real lane plus signed imaginary lane, one bin per strobe, with frames delimited by sync_o.
- Computes an alpha-max-beta-min magnitude per bin and tracks the largest bin over one frame.
- Reports the index and magnitude of that bin, plus a threshold flag, to the application logic after each frame.
- All logic runs in a single global_clk domain; fft_clk-rate pacing arrives as a bin_valid strobe.

Parameters:
- N_BINS, 128, bins per frame (power of two, 4..256); index width IDX_W = log2(N_BINS).
- DATA_W, 8, width of each signed input lane.
- SKIP_DC, 1, when 1 bin 0 is excluded from the peak search.
- THRESH, 16, minimum magnitude for peak_found = 1.

Ports:
- global_clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- sync_o  in  1  frame marker from FFT; rising edge starts a frame.
- bin_valid  in  1  one-cycle strobe; fft_re and fft_im are valid.
- fft_re  in  DATA_W  signed real part of the current bin.
- fft_im  in  DATA_W  signed imaginary part of the current bin.
- peak_bin  out  IDX_W  index of the largest bin in the last frame.
- peak_mag  out  DATA_W  magnitude of that bin.
- peak_found  out  1  peak_mag >= THRESH.
- peak_valid  out  1  one-cycle pulse; the three outputs above were updated.
- frame_abort  out  1  one-cycle pulse; a frame was cut short by a new sync edge.
- busy  out  1  high while a frame is being accumulated or drained.

Behaviour:
- Reset:
  - Synchronous, active-high: the reset takes effect on the global_clk edge where rst = 1.
  - All outputs go to 0, the FSM goes to IDLE, the pipeline and the sync edge register are cleared.
  - An asserted rst mid-frame discards that frame; no peak_valid or frame_abort is produced for it.
- Sync edge: sync_o is registered each cycle; an edge exists when sync_o = 1 and the previous sample = 0. There is no metastability stage because sync_o is generated on-chip.
- FSM:
  - IDLE: busy = 0. On a sync edge, clear bin_cnt and the running max, then go to ACCUM. bin_valid is ignored in IDLE.
  - ACCUM: busy = 1. Each bin_valid beat enters the pipeline tagged with bin_cnt, and bin_cnt increments.
    - The beat with bin_cnt = N_BINS-1 moves the FSM to DRAIN.
    - A bin_valid in the same cycle as the sync edge that caused the IDLE->ACCUM transition is ignored; bin 0 is the first beat after that cycle.
  - DRAIN: busy = 1. Wait until the last beat has passed the compare stage, then go to REPORT. Sync edges are ignored in DRAIN.
  - REPORT: one cycle. Load peak_bin, peak_mag and peak_found; pulse peak_valid; go to IDLE. If sync_o rose during DRAIN or REPORT, that frame is lost; the next edge is required.
- Magnitude pipeline (3 stages, one beat per cycle, no back-pressure):
  - S1: a = |fft_re|, b = |fft_im|, each unsigned DATA_W bits. The abs of the most negative value (-128) is 128.
  - S2: mag = max(a,b) + (min(a,b) >> 1). This is unsigned DATA_W bits and cannot overflow (max 128 + 64 = 192 for DATA_W = 8).
  - S3: compare against the running max. Update only if mag > max (strictly greater), so on ties the lowest bin index wins.
  - When SKIP_DC = 1, bin 0 never updates the running max.
  - The running max starts at 0 with index 0. For an all-zero frame, or a frame with only DC energy and SKIP_DC = 1, the report is peak_bin = 0 (or 1 if SKIP_DC), peak_mag = 0.
- Latency: peak_valid asserts exactly 4 cycles after the global_clk edge that samples the final bin_valid beat (3 pipeline stages plus REPORT).
- Outputs hold their values between peak_valid pulses.
- Back-to-back beats are allowed: bin_valid may be high every cycle.
- Abort:
  - A sync edge in ACCUM with bin_cnt > 0 pulses frame_abort in the next cycle.
  - The pipeline contents and running max are flushed, and a new frame starts with bin_cnt = 0.
  - peak_* outputs keep their previous values.
- peak_found is computed from the final max at REPORT: 1 iff peak_mag >= THRESH.

Test Plan:
- Reset then a single frame: 128 beats all (0,0) except bin 37 = (re=-100, im=40) -> peak_bin = 37, peak_mag = 120, peak_found = 1, peak_valid exactly 4 cycles after the last beat, busy low the cycle after.
- Tie and DC skip with SKIP_DC = 1: bin 0 = (127,127), bins 5 and 9 = (50,0) -> peak_bin = 5, peak_mag = 50; the DC bin is not reported.
- Extremes: bin 64 = (-128,-128) -> peak_mag = 192. An all-zero frame -> peak_bin = 1, peak_mag = 0, peak_found = 0. A frame with max 15 and THRESH = 16 -> peak_found = 0.
- Strobe pacing: bin_valid every 2nd cycle, matching the fft_clk = global_clk/2 rate, then the same frame with bin_valid every cycle -> identical peak_bin and peak_mag.
- Abort: sync edge after 60 beats -> frame_abort pulses once and the old peak_* values hold. A following full frame with peak at bin 100 -> peak_bin = 100.
- rst asserted for 1 cycle at beat 70, then a new sync and full frame -> no peak_valid for the reset frame; outputs are 0 until the new frame reports correctly.
